// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: FSM state encoding and requester IDs.
// Optional round-robin arbitration is enabled with the MEM_ARB_RR_EN macro.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IF = 2'd1,
        GNT_DM = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_DM = 1'b1;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational winner selection between the fetch (IF) and data (DM) requesters.
// With MEM_ARB_RR_EN defined, ties are broken against the last granted side.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic if_req,
    input  logic dm_req,
    input  logic halt,
    input  logic last,
    output logic winner,
    output logic valid
);

    logic if_ok;

    assign if_ok = if_req & ~halt;

`ifndef MEM_ARB_RR_EN
    // Fixed priority ignores the pointer; keep it visibly consumed.
    logic unused_last;
    assign unused_last = last;
`endif

    always_comb begin
        winner = REQ_IF;
        valid  = if_ok | dm_req;
        if (dm_req && if_ok) begin
`ifdef MEM_ARB_RR_EN
            winner = (last == REQ_DM) ? REQ_IF : REQ_DM;
`else
            winner = REQ_DM;
`endif
        end else if (dm_req) begin
            winner = REQ_DM;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one memory between instruction fetch and data access.
// Define MEM_ARB_RR_EN for round-robin tie breaking; default is fixed DM priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          halt,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    input  logic          dm_req,
    input  logic          dm_wr,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_done,
    output logic          mem_en,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_done,
    output logic          busy
);

    state_t        state;
    logic [AW-1:0] hold_addr;
    logic          hold_wr;
    logic [DW-1:0] hold_wdata;
    logic          last_grant;
    logic          pick_winner;
    logic          pick_valid;

    arb_pick u_arb_pick (
        .if_req (if_req),
        .dm_req (dm_req),
        .halt   (halt),
        .last   (last_grant),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    // The memory bus is driven straight from the hold registers so it cannot
    // follow requester inputs once a grant has been taken.
    assign mem_addr  = hold_addr;
    assign mem_wdata = hold_wdata;
    assign mem_wr    = mem_en & hold_wr;

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= REQ_IF;
        end else if (state == IDLE && pick_valid) begin
            last_grant <= pick_winner;
        end
    end
`else
    assign last_grant = REQ_IF;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            hold_addr  <= '0;
            hold_wr    <= 1'b0;
            hold_wdata <= '0;
            mem_en     <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            if_done    <= 1'b0;
            dm_done    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            if_done <= 1'b0;
            dm_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        busy   <= 1'b1;
                        mem_en <= 1'b1;
                        if (pick_winner == REQ_DM) begin
                            state      <= GNT_DM;
                            hold_addr  <= dm_addr;
                            hold_wr    <= dm_wr;
                            hold_wdata <= dm_wdata;
                        end else begin
                            state      <= GNT_IF;
                            hold_addr  <= if_addr;
                            hold_wr    <= 1'b0;
                            hold_wdata <= '0;
                        end
                    end
                end
                GNT_IF: begin
                    if (mem_done) begin
                        if_rdata <= mem_rdata;
                        if_done  <= 1'b1;
                        mem_en   <= 1'b0;
                        state    <= RESP;
                    end
                end
                GNT_DM: begin
                    if (mem_done) begin
                        dm_rdata <= mem_rdata;
                        dm_done  <= 1'b1;
                        mem_en   <= 1'b0;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy   <= 1'b0;
                    mem_en <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; the bench acts as the shared memory.
// Honours MEM_ARB_RR_EN when deciding which side should win a tie.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_done;
    logic        dm_req;
    logic        dm_wr;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic [15:0] dm_rdata;
    logic        dm_done;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_done;
    logic        busy;

    int          checks   = 0;
    int          failures = 0;
    logic        model_last;
    logic [15:0] exp_if_rdata;
    logic [15:0] exp_dm_rdata;

    typedef struct {
        logic        ifr;
        logic        dmr;
        logic        h;
        logic        wr;
        logic [15:0] ia;
        logic [15:0] da;
        logic [15:0] wd;
        logic [15:0] rd;
        int          delay;
        logic        exp_side;
        logic        exp_side_rr;
    } vec_t;

    vec_t vecs [7];

    mem_arbiter #(.AW(16), .DW(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .halt      (halt),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .dm_req    (dm_req),
        .dm_wr     (dm_wr),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_done   (dm_done),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Expected tie-break: DM wins unless round-robin says IF's turn.
    function automatic logic pickModel(input logic ifr, input logic dmr, input logic h);
        logic w;
        w = 1'b0;
        if (dmr && ifr && !h) begin
`ifdef MEM_ARB_RR_EN
            w = (model_last == 1'b1) ? 1'b0 : 1'b1;
`else
            w = 1'b1;
`endif
        end else if (dmr) begin
            w = 1'b1;
        end
        return w;
    endfunction

    // Wait for a grant to `side`, act as memory with `delay` stall cycles,
    // then check the response cycle and that done pulses only once.
    task automatic applyStimulus(input logic side, input int delay, input logic [15:0] rd,
                                 input logic drop_mid);
        logic [15:0] ea;
        logic [15:0] ew;
        logic        ewr;
        int          waited;
        ea  = side ? dm_addr : if_addr;
        ew  = side ? dm_wdata : 16'h0000;
        ewr = side ? dm_wr : 1'b0;
        waited = 0;
        while (!mem_en && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!mem_en) begin
            checks++;
            failures++;
            $display("[TB] FAIL grant_timeout actual=mem_en_low required=mem_en_high");
            return;
        end
        model_last = side;
        checkOutput("grant_addr", mem_addr, ea);
        checkOutput("grant_wr", mem_wr, ewr);
        checkOutput("grant_wdata", mem_wdata, ew);
        checkOutput("grant_busy", busy, 1);
        if (side) begin
            dm_addr  = dm_addr ^ 16'hFFFF;
            dm_wdata = dm_wdata ^ 16'hFFFF;
            if (drop_mid) dm_req = 1'b0;
        end else begin
            if_addr = if_addr ^ 16'hFFFF;
            if (drop_mid) if_req = 1'b0;
        end
        for (int d = 0; d < delay; d++) begin
            checkOutput("stall_en", mem_en, 1);
            checkOutput("stall_addr", mem_addr, ea);
            checkOutput("stall_wr", mem_wr, ewr);
            checkOutput("stall_wdata", mem_wdata, ew);
            checkOutput("stall_done", {if_done, dm_done}, 0);
            @(negedge clk);
        end
        mem_done  = 1'b1;
        mem_rdata = rd;
        @(negedge clk);
        mem_done  = 1'b0;
        mem_rdata = 16'h0000;
        if (side) exp_dm_rdata = rd;
        else      exp_if_rdata = rd;
        checkOutput("resp_en", mem_en, 0);
        checkOutput("resp_wr", mem_wr, 0);
        checkOutput("resp_busy", busy, 1);
        checkOutput("resp_if_done", if_done, !side);
        checkOutput("resp_dm_done", dm_done, side);
        checkOutput("resp_if_rdata", if_rdata, exp_if_rdata);
        checkOutput("resp_dm_rdata", dm_rdata, exp_dm_rdata);
        if (side) dm_req = 1'b0;
        else      if_req = 1'b0;
        @(negedge clk);
        checkOutput("done_once", {if_done, dm_done}, 0);
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_en", mem_en, 0);
    endtask

    initial begin
        logic es;
        logic s;
        int   waited;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 16'hABCD, 1, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0200, 16'h0000, 16'h5555, 2, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0100, 16'h1234, 16'h0000, 5, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0040, 16'h0300, 16'h0000, 16'h1111, 1, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0050, 16'h0400, 16'hBEEF, 16'h2222, 3, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0001, 1, 1'b1, 1'b1};

        rst = 1'b1; halt = 1'b0; if_req = 1'b0; if_addr = 16'h0; dm_req = 1'b0;
        dm_wr = 1'b0; dm_addr = 16'h0; dm_wdata = 16'h0; mem_rdata = 16'h0; mem_done = 1'b0;
        model_last = 1'b0;
        exp_if_rdata = 16'h0;
        exp_dm_rdata = 16'h0;
        repeat (2) @(negedge clk);
        checkOutput("reset_mem", {mem_en, mem_wr, mem_addr, mem_wdata}, 0);
        checkOutput("reset_rdata", {if_rdata, dm_rdata}, 0);
        checkOutput("reset_flags", {if_done, dm_done, busy}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single transactions from IDLE, loser (if any) withdrawn afterwards.
        for (int i = 0; i < 7; i++) begin
            halt = vecs[i].h; if_req = vecs[i].ifr; dm_req = vecs[i].dmr;
            if_addr = vecs[i].ia; dm_addr = vecs[i].da; dm_wr = vecs[i].wr; dm_wdata = vecs[i].wd;
`ifdef MEM_ARB_RR_EN
            es = vecs[i].exp_side_rr;
`else
            es = vecs[i].exp_side;
`endif
            applyStimulus(es, vecs[i].delay, vecs[i].rd, 1'b0);
            if_req = 1'b0; dm_req = 1'b0; halt = 1'b0; dm_wr = 1'b0;
        end

        // Simultaneous requests: the loser is served right after RESP.
        if_req = 1'b1; dm_req = 1'b1; if_addr = 16'h0A00; dm_addr = 16'h0B00;
        s = pickModel(1'b1, 1'b1, 1'b0);
        applyStimulus(s, 1, 16'h3333, 1'b0);
        applyStimulus(!s, 1, 16'h4444, 1'b0);
        if_req = 1'b0; dm_req = 1'b0;

        // Both sides keep re-requesting: fixed priority starves IF, round-robin alternates.
        if_req = 1'b1; dm_req = 1'b1; dm_wr = 1'b0;
        for (int p = 0; p < 8; p++) begin
            s = pickModel(1'b1, 1'b1, 1'b0);
            applyStimulus(s, 1, 16'h6000 + 16'(p), 1'b0);
            if (s) dm_req = 1'b1;
            else   if_req = 1'b1;
        end
        if_req = 1'b0; dm_req = 1'b0;

        // Halt blocks fetch but not data; fetch proceeds once halt drops.
        halt = 1'b1; if_req = 1'b1; dm_req = 1'b1; if_addr = 16'h0C00; dm_addr = 16'h0D00;
        applyStimulus(1'b1, 1, 16'h7777, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("halt_no_grant", {mem_en, busy}, 0);
        end
        halt = 1'b0;
        applyStimulus(1'b0, 2, 16'h8888, 1'b0);

        // Request dropped mid-grant still completes with a single done.
        dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0E00;
        applyStimulus(1'b1, 3, 16'h9999, 1'b1);

        // Asynchronous reset in the middle of a DM grant.
        dm_req = 1'b1; dm_addr = 16'h0F00;
        waited = 0;
        while (!mem_en && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("rst_pre_grant", mem_en, 1);
        #1 rst = 1'b1;
        #1;
        checkOutput("rst_async_en", mem_en, 0);
        checkOutput("rst_async_busy", busy, 0);
        checkOutput("rst_async_rdata", dm_rdata, 0);
        dm_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_last = 1'b0;
        exp_if_rdata = 16'h0;
        exp_dm_rdata = 16'h0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("rst_no_done", {dm_done, if_done, mem_en}, 0);
        end
        dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0123; dm_wdata = 16'h4567;
        applyStimulus(1'b1, 1, 16'h0F0F, 1'b0);
        dm_req = 1'b0; dm_wr = 1'b0;

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
